time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000000: clock cycles per second tick.
REQ-002 Parameter SCAN_DIV, default 1024: clock cycles per scan-phase step.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_mode  input  1  raw mode button, active-high, asynchronous to clock.
REQ-006 btn_inc  input  1  raw increment button, active-high, asynchronous to clock.
REQ-007 disp_sel  input  1  run-mode view select: 0 = minutes:seconds, 1 = hours:minutes.
REQ-008 data_show  output  12  [11:6] = high display field, [5:0] = low display field, binary 0..59.
REQ-009 byte_status  output  3  display scan phase, consumed by the segment display stage.
REQ-010 set_mode  output  2  00 = RUN, 01 = SET_HOUR, 10 = SET_MIN; 11 is never driven.

Function
REQ-011 Prescaler: counts 0..TICKS_PER_SEC-1 in RUN. sec_tick asserts for one cycle when the count equals TICKS_PER_SEC-1, and the count wraps to 0 on that cycle.
REQ-012 Counters: sec 0..59, min 0..59, hour 0..23, each 6 bits. Every sec_tick increments sec.
- sec 59 -> 0 carries into min.
- min 59 -> 0 carries into hour.
- hour 23 -> 0.
- All carries resolve in the same cycle: 23:59:59 -> 00:00:00 on one tick.
REQ-013 Button path, per button: 2-flop synchronizer, then rising-edge detect. An input high first sampled at edge N produces a one-cycle pulse that acts at edge N+2. Holding the button produces no further pulses.
REQ-014 FSM states: RUN, SET_HOUR, SET_MIN. A mode pulse steps RUN -> SET_HOUR -> SET_MIN -> RUN.
REQ-015 SET_HOUR: an inc pulse sets hour = (hour+1) mod 24. Prescaler and sec are held.
REQ-016 SET_MIN: an inc pulse sets min = (min+1) mod 60. No carry into hour. Prescaler and sec are held.
REQ-017 Transition SET_MIN -> RUN clears sec and prescaler to 0 in the same cycle.
REQ-018 Simultaneous mode and inc pulses: the mode transition wins and the inc pulse is discarded.
REQ-019 Inc pulses in RUN are ignored.
REQ-020 data_show is driven directly from the counter registers, with zero added latency:
- RUN with disp_sel=0: {min, sec}.
- RUN with disp_sel=1: {hour, min}.
- SET_HOUR or SET_MIN: {hour, min}, regardless of disp_sel.
REQ-021 Scan counter: a divider counts 0..SCAN_DIV-1. At terminal count, byte_status increments modulo 8 (7 -> 0). It runs in every FSM state.
REQ-022 set_mode is the registered FSM state encoding.

Reset
REQ-023 reset low asynchronously forces:
- FSM = RUN, set_mode = 00.
- sec = min = hour = 0, so data_show = 0.
- byte_status = 0.
- Prescaler, scan divider and all synchronizer/edge flops = 0.
REQ-024 Reset asserted mid-operation (any state, any count) yields exactly the REQ-023 state. The first update after deassertion happens at the first rising clock edge with reset high.

Structure
REQ-025 Shared package time_keeper_pkg holds:
- the FSM state encoding (RUN/SET_HOUR/SET_MIN);
- constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
- field width 6.
REQ-026 Sub-module btn_sync_edge (synchronizer plus edge detect) is instantiated twice, once for btn_mode and once for btn_inc.

Verification (bench uses TICKS_PER_SEC=4, SCAN_DIV=2)
REQ-027 Reset, then 240 clocks in RUN with disp_sel=0 -> data_show = {6'd1, 6'd0} (00:01:00). byte_status has cycled 0..7 repeatedly, wrapping 7 -> 0.
REQ-028 Preload 23:59:59 via set mode, return to RUN, run to the next tick:
- disp_sel=1 -> {0, 0} after hour/min rollover.
- Also check 59 -> 0 on sec alone.
REQ-029 Press btn_mode once, then btn_inc 25 times -> set_mode = 01 and hour = 1 (wrap at 24). sec is unchanged throughout.
REQ-030 In SET_MIN, assert btn_mode and btn_inc on the same cycle -> set_mode = 00, min unchanged, sec = 0, prescaler = 0.
REQ-031 Assert reset mid-count in SET_MIN with min = 37 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first sec_tick occurs TICKS_PER_SEC cycles later.
REQ-032 Hold btn_inc high for 20 cycles in SET_HOUR -> hour increments exactly once, 2 edges after first sampling.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the time_keeper clock: FSM encoding,
// counter limits and the wrapping increment used by every time field.
package time_keeper_pkg;

    localparam int FIELD_W = 6;

    typedef logic [FIELD_W-1:0] field_t;

    localparam field_t SEC_MAX  = 6'd59;
    localparam field_t MIN_MAX  = 6'd59;
    localparam field_t HOUR_MAX = 6'd23;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } tk_state_t;

    function automatic field_t wrap_inc(input field_t val, input field_t max_val);
        return (val == max_val) ? '0 : val + 1'b1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; a press sampled
// at edge N yields a single pulse that is consumed at edge N+2.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            // stage boundary: synchronized level -> edge history
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds clock with a two-button set mode and a free-running
// display scan phase for the downstream segment driver.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000000,
    parameter int SCAN_DIV      = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        disp_sel,
    output logic [11:0] data_show,
    output logic [2:0]  byte_status,
    output logic [1:0]  set_mode
);

    localparam int PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    tk_state_t          state;
    field_t             sec_cnt;
    field_t             min_cnt;
    field_t             hour_cnt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [SCAN_W-1:0]  scan_cnt;
    logic               mode_pulse;
    logic               inc_pulse;
    logic               sec_tick;

    btn_sync_edge u_mode_btn (
        .clock (clock),
        .reset (reset),
        .btn   (btn_mode),
        .pulse (mode_pulse)
    );

    btn_sync_edge u_inc_btn (
        .clock (clock),
        .reset (reset),
        .btn   (btn_inc),
        .pulse (inc_pulse)
    );

    assign sec_tick = (state == ST_RUN) && (pre_cnt == PRE_LAST);

    // Mode pulses are tested before inc pulses so a simultaneous pair only changes state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            sec_cnt  <= '0;
            min_cnt  <= '0;
            hour_cnt <= '0;
            pre_cnt  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    pre_cnt <= sec_tick ? '0 : pre_cnt + 1'b1;
                    if (sec_tick) begin
                        sec_cnt <= wrap_inc(sec_cnt, SEC_MAX);
                        if (sec_cnt == SEC_MAX) begin
                            min_cnt <= wrap_inc(min_cnt, MIN_MAX);
                            if (min_cnt == MIN_MAX)
                                hour_cnt <= wrap_inc(hour_cnt, HOUR_MAX);
                        end
                    end
                    if (mode_pulse)
                        state <= ST_SET_HOUR;
                end
                ST_SET_HOUR: begin
                    if (mode_pulse)
                        state <= ST_SET_MIN;
                    else if (inc_pulse)
                        hour_cnt <= wrap_inc(hour_cnt, HOUR_MAX);
                end
                ST_SET_MIN: begin
                    if (mode_pulse) begin
                        state   <= ST_RUN;
                        sec_cnt <= '0;
                        pre_cnt <= '0;
                    end else if (inc_pulse) begin
                        min_cnt <= wrap_inc(min_cnt, MIN_MAX);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt    <= '0;
            byte_status <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt    <= '0;
            byte_status <= byte_status + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign set_mode = state;

    always_comb begin
        data_show = {hour_cnt, min_cnt};
        if (state == ST_RUN && !disp_sel)
            data_show = {min_cnt, sec_cnt};
    end

endmodule

// File: tb/tb_time_keeper.sv
// Scenario bench for time_keeper with a fast prescaler (4) and scan divider (2).
module tb_time_keeper;

    logic        clock;
    logic        reset;
    logic        btn_mode;
    logic        btn_inc;
    logic        disp_sel;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic [1:0]  set_mode;

    int checks = 0;
    int errors = 0;

    logic [11:0] data_q[$];
    logic [2:0]  bs_q[$];

    time_keeper #(.TICKS_PER_SEC(4), .SCAN_DIV(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .disp_sel    (disp_sel),
        .data_show   (data_show),
        .byte_status (byte_status),
        .set_mode    (set_mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called 1ns after an edge; returns 6ns after an edge with reset released.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #3 reset = 1'b1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        logic [11:0] e;
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; disp_sel = 1'b0;
        tick(2);
        checks++;
        if (data_show !== 12'd0) begin errors++; $display("FAIL reset_data got %h exp 000", data_show); end
        checks++;
        if (set_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got %b exp 00", set_mode); end
        checks++;
        if (byte_status !== 3'd0) begin errors++; $display("FAIL reset_bs got %0d exp 0", byte_status); end
        #5 reset = 1'b1;
        bs_q.push_back(3'd1);
        data_q.push_back(12'd0);
        tick(2);
        checks++;
        if (byte_status !== bs_q[0]) begin errors++; $display("FAIL reset_first_bs got %0d exp %0d", byte_status, bs_q[0]); end
        void'(bs_q.pop_front());
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL reset_first_data got %h exp %h", data_show, e); end
    endtask

    task automatic test_run();
        logic [11:0] e;
        logic [2:0]  eb;
        int t;
        apply_reset();
        disp_sel = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            t = k / 4;
            data_q.push_back({6'((t / 60) % 60), 6'(t % 60)});
            bs_q.push_back(3'((k / 2) % 8));
            tick(1);
            e  = data_q.pop_front();
            eb = bs_q.pop_front();
            checks++;
            if (data_show !== e) begin errors++; $display("FAIL run_data cyc %0d got %h exp %h", k, data_show, e); end
            checks++;
            if (byte_status !== eb) begin errors++; $display("FAIL run_bs cyc %0d got %0d exp %0d", k, byte_status, eb); end
        end
    endtask

    task automatic test_rollover();
        logic [11:0] e;
        apply_reset();
        disp_sel = 1'b0;
        press(1'b1, 1'b0);
        checks++;
        if (set_mode !== 2'b01) begin errors++; $display("FAIL roll_sethour got %b exp 01", set_mode); end
        repeat (23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        checks++;
        if (set_mode !== 2'b10) begin errors++; $display("FAIL roll_setmin got %b exp 10", set_mode); end
        repeat (59) press(1'b0, 1'b1);
        data_q.push_back({6'd59, 6'd0});
        press(1'b1, 1'b0);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e || set_mode !== 2'b00) begin errors++; $display("FAIL roll_enter_run got %h/%b exp %h/00", data_show, set_mode, e); end
        data_q.push_back({6'd59, 6'd59});
        tick(236);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_235959_ms got %h exp %h", data_show, e); end
        data_q.push_back({6'd23, 6'd59});
        disp_sel = 1'b1; #1;
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_235959_hm got %h exp %h", data_show, e); end
        data_q.push_back(12'd0);
        tick(4);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_midnight_hm got %h exp %h", data_show, e); end
        data_q.push_back(12'd0);
        disp_sel = 1'b0; #1;
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_midnight_ms got %h exp %h", data_show, e); end
        data_q.push_back({6'd0, 6'd59});
        tick(236);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_sec59 got %h exp %h", data_show, e); end
        data_q.push_back({6'd1, 6'd0});
        tick(4);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_sec_wrap got %h exp %h", data_show, e); end
        data_q.push_back({6'd0, 6'd1});
        disp_sel = 1'b1; #1;
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL roll_sec_wrap_hm got %h exp %h", data_show, e); end
        disp_sel = 1'b0;
    endtask

    task automatic test_hour_wrap();
        logic [11:0] e;
        apply_reset();
        disp_sel = 1'b0;
        press(1'b1, 1'b0);
        repeat (25) press(1'b0, 1'b1);
        data_q.push_back({6'd1, 6'd0});
        tick(3);
        e = data_q.pop_front();
        checks++;
        if (set_mode !== 2'b01) begin errors++; $display("FAIL hwrap_mode got %b exp 01", set_mode); end
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL hwrap_data got %h exp %h", data_show, e); end
    endtask

    task automatic test_simultaneous();
        logic [11:0] e;
        apply_reset();
        disp_sel = 1'b0;
        tick(28);
        data_q.push_back({6'd0, 6'd7});
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL simul_pre got %h exp %h", data_show, e); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        data_q.push_back({6'd0, 6'd5});
        tick(6);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e || set_mode !== 2'b10) begin errors++; $display("FAIL simul_setmin got %h/%b exp %h/10", data_show, set_mode, e); end
        data_q.push_back({6'd5, 6'd0});
        press(1'b1, 1'b1);
        e = data_q.pop_front();
        checks++;
        if (set_mode !== 2'b00) begin errors++; $display("FAIL simul_mode got %b exp 00", set_mode); end
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL simul_data got %h exp %h", data_show, e); end
        data_q.push_back({6'd5, 6'd0});
        tick(3);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL simul_pre_cleared got %h exp %h", data_show, e); end
        data_q.push_back({6'd5, 6'd1});
        tick(1);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL simul_first_tick got %h exp %h", data_show, e); end
        data_q.push_back({6'd0, 6'd5});
        press(1'b0, 1'b1);
        disp_sel = 1'b1; #1;
        e = data_q.pop_front();
        checks++;
        if (data_show !== e || set_mode !== 2'b00) begin errors++; $display("FAIL run_inc_ignored got %h/%b exp %h/00", data_show, set_mode, e); end
        disp_sel = 1'b0;
    endtask

    task automatic test_reset_mid_set();
        logic [11:0] e;
        apply_reset();
        disp_sel = 1'b0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (37) press(1'b0, 1'b1);
        data_q.push_back({6'd0, 6'd37});
        e = data_q.pop_front();
        checks++;
        if (data_show !== e || set_mode !== 2'b10) begin errors++; $display("FAIL mid_pre got %h/%b exp %h/10", data_show, set_mode, e); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (data_show !== 12'd0 || set_mode !== 2'b00 || byte_status !== 3'd0) begin
            errors++;
            $display("FAIL mid_async got %h/%b/%0d exp 000/00/0", data_show, set_mode, byte_status);
        end
        #2 reset = 1'b1;
        data_q.push_back(12'd0);
        tick(3);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL mid_before_tick got %h exp %h", data_show, e); end
        data_q.push_back({6'd0, 6'd1});
        tick(1);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e) begin errors++; $display("FAIL mid_first_tick got %h exp %h", data_show, e); end
    endtask

    task automatic test_hold_inc();
        logic [11:0] e;
        apply_reset();
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        data_q.push_back(12'd0);
        data_q.push_back(12'd0);
        data_q.push_back({6'd1, 6'd0});
        for (int k = 0; k < 3; k++) begin
            tick(1);
            e = data_q.pop_front();
            checks++;
            if (data_show !== e) begin errors++; $display("FAIL hold_edge%0d got %h exp %h", k, data_show, e); end
        end
        data_q.push_back({6'd1, 6'd0});
        tick(17);
        btn_inc = 1'b0;
        tick(5);
        e = data_q.pop_front();
        checks++;
        if (data_show !== e || set_mode !== 2'b01) begin errors++; $display("FAIL hold_once got %h/%b exp %h/01", data_show, set_mode, e); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_rollover();
        test_hour_wrap();
        test_simultaneous();
        test_reset_mid_set();
        test_hold_inc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
